// File: rtl/traffic_intersection_ctrl.sv
// Two-way intersection controller: main/side lights, all-red clearance, pedestrian
// shortening, night blinking-yellow mode and a 2-digit 7-segment countdown.
module traffic_intersection_ctrl #(
    parameter int unsigned pSECOND_CNT_VAL  = 99,
    parameter int unsigned pTIME_GREEN_MAIN = 15,
    parameter int unsigned pTIME_GREEN_SIDE = 10,
    parameter int unsigned pTIME_YELLOW     = 3,
    parameter int unsigned pTIME_ALL_RED    = 2,
    parameter int unsigned pTIME_PED_SHORT  = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       night_mode,
    input  logic       ped_req,
    output logic       main_g,
    output logic       main_y,
    output logic       main_r,
    output logic       side_g,
    output logic       side_y,
    output logic       side_r,
    output logic       ped_walk,
    output logic       ped_wait,
    output logic [6:0] seg_a,
    output logic [6:0] seg_b
);

    localparam int unsigned PW = (pSECOND_CNT_VAL > 0) ? $clog2(pSECOND_CNT_VAL + 1) : 1;
    localparam logic [PW-1:0] TC = PW'(pSECOND_CNT_VAL);

    localparam logic [6:0] T_GM = 7'(pTIME_GREEN_MAIN);
    localparam logic [6:0] T_GS = 7'(pTIME_GREEN_SIDE);
    localparam logic [6:0] T_Y  = 7'(pTIME_YELLOW);
    localparam logic [6:0] T_AR = 7'(pTIME_ALL_RED);
    localparam logic [6:0] T_PS = 7'(pTIME_PED_SHORT);

    // Lamp vector order: {main_g, main_y, main_r, side_g, side_y, side_r, ped_walk}
    localparam logic [6:0] LAMPS_RESET = 7'b001_001_0;

    typedef enum logic [2:0] {
        S_ALL_RED2,
        S_MAIN_GREEN,
        S_MAIN_YELLOW,
        S_ALL_RED1,
        S_SIDE_GREEN,
        S_SIDE_YELLOW,
        S_NIGHT
    } state_t;

    state_t        state_q, state_d;
    logic [6:0]    timer_q, timer_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          blink_q, blink_d;
    logic          ped_wait_q, ped_wait_d;
    logic [6:0]    lamps_q, lamps_d;
    logic          tick;
    logic [3:0]    tens, units;

    // Prescaler
    assign tick = en && (presc_q == TC);

    always_comb begin
        presc_d = presc_q;
        if (en) begin
            presc_d = (presc_q == TC) ? '0 : presc_q + 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_ALL_RED2;
            timer_q    <= T_AR;
            presc_q    <= '0;
            blink_q    <= 1'b0;
            ped_wait_q <= 1'b0;
            lamps_q    <= LAMPS_RESET;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            presc_q    <= presc_d;
            blink_q    <= blink_d;
            ped_wait_q <= ped_wait_d;
            lamps_q    <= lamps_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        blink_d = blink_q;
        if (tick) begin
            if (state_q == S_NIGHT) begin
                if (!night_mode) begin
                    state_d = S_ALL_RED2;
                    timer_d = T_AR;
                    blink_d = 1'b0;
                end else begin
                    blink_d = ~blink_q;
                end
            end else if (timer_q == 7'd1) begin
                case (state_q)
                    S_MAIN_GREEN:  begin state_d = S_MAIN_YELLOW; timer_d = T_Y;  end
                    S_MAIN_YELLOW: begin state_d = S_ALL_RED1;    timer_d = T_AR; end
                    S_ALL_RED1:    begin state_d = S_SIDE_GREEN;  timer_d = T_GS; end
                    S_SIDE_GREEN:  begin state_d = S_SIDE_YELLOW; timer_d = T_Y;  end
                    S_SIDE_YELLOW: begin state_d = S_ALL_RED2;    timer_d = T_AR; end
                    S_ALL_RED2: begin
                        if (night_mode) begin
                            state_d = S_NIGHT;
                            blink_d = 1'b1;
                        end else begin
                            state_d = S_MAIN_GREEN;
                            timer_d = T_GM;
                        end
                    end
                    default: begin state_d = S_ALL_RED2; timer_d = T_AR; end
                endcase
            end else if (state_q == S_MAIN_GREEN && ped_wait_q && timer_q > T_PS) begin
                timer_d = T_PS;
            end else begin
                timer_d = timer_q - 7'd1;
            end
        end

        // Entry into side green serves the request, even against a same-cycle press
        ped_wait_d = ped_wait_q | ped_req;
        if (state_d == S_SIDE_GREEN && state_q != S_SIDE_GREEN) begin
            ped_wait_d = 1'b0;
        end
    end

    // Output logic: lamps derived from the next state so they switch on the same edge
    always_comb begin
        case (state_d)
            S_MAIN_GREEN:  lamps_d = 7'b100_001_0;
            S_MAIN_YELLOW: lamps_d = 7'b010_001_0;
            S_SIDE_GREEN:  lamps_d = 7'b001_100_1;
            S_SIDE_YELLOW: lamps_d = 7'b001_010_0;
            S_NIGHT:       lamps_d = {1'b0, blink_d, 1'b0, 1'b0, blink_d, 1'b0, 1'b0};
            default:       lamps_d = LAMPS_RESET;
        endcase
    end

    assign {main_g, main_y, main_r, side_g, side_y, side_r, ped_walk} = lamps_q;
    assign ped_wait = ped_wait_q;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    assign tens  = 4'(timer_q / 7'd10);
    assign units = 4'(timer_q % 7'd10);
    assign seg_a = (state_q == S_NIGHT) ? '1 : seg7(tens);
    assign seg_b = (state_q == S_NIGHT) ? '1 : seg7(units);

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Bench for traffic_intersection_ctrl: phase tables plus hand sequences for pedestrian,
// enable freeze, night mode and asynchronous reset; expectations flow through a scoreboard queue.
`timescale 1ns/1ps
module tb_traffic_intersection_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, en, night_mode, ped_req;
    logic       main_g, main_y, main_r, side_g, side_y, side_r, ped_walk, ped_wait;
    logic [6:0] seg_a, seg_b;
    logic [21:0] act;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    localparam logic [5:0] L_AR = 6'b001_001;
    localparam logic [5:0] L_MG = 6'b100_001;
    localparam logic [5:0] L_MY = 6'b010_001;
    localparam logic [5:0] L_SG = 6'b001_100;
    localparam logic [5:0] L_SY = 6'b001_010;

    typedef struct {
        string       name;
        logic [21:0] val;
    } exp_t;

    typedef struct {
        string       name;
        logic [5:0]  lights;
        logic        walk;
        logic        pend;
        int          n;
    } phase_t;

    exp_t   sb[$];
    phase_t seq1[7];

    traffic_intersection_ctrl #(
        .pSECOND_CNT_VAL(3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .night_mode(night_mode),
        .ped_req   (ped_req),
        .main_g    (main_g),
        .main_y    (main_y),
        .main_r    (main_r),
        .side_g    (side_g),
        .side_y    (side_y),
        .side_r    (side_r),
        .ped_walk  (ped_walk),
        .ped_wait  (ped_wait),
        .seg_a     (seg_a),
        .seg_b     (seg_b)
    );

    always #5 clk = ~clk;

    assign act = {main_g, main_y, main_r, side_g, side_y, side_r, ped_walk, ped_wait, seg_a, seg_b};

    function automatic logic [6:0] seg7(input int unsigned d);
        logic [6:0] lut [10];
        lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return lut[d];
    endfunction

    function automatic logic [13:0] digits(input int unsigned v);
        return {seg7(v / 10), seg7(v % 10)};
    endfunction

    function automatic phase_t ph(input string name, input logic [5:0] lights,
                                  input logic walk, input logic pend, input int n);
        phase_t p;
        p.name = name; p.lights = lights; p.walk = walk; p.pend = pend; p.n = n;
        return p;
    endfunction

    task automatic expect_out(input string name, input logic [5:0] lights, input logic walk,
                              input logic pend, input logic [13:0] segs);
        exp_t e;
        e.name = name;
        e.val  = {lights, walk, pend, segs};
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL scoreboard: no expectation queued, got %b", act);
            return;
        end
        e = sb.pop_front();
        if (act !== e.val) begin
            n_errors++;
            $display("FAIL %s: got %b required %b (g y r g y r walk wait seg_a seg_b)", e.name, act, e.val);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick();
        step(4);
    endtask

    // Checks the displayed countdown from from_k down to to_k, one tick apart
    task automatic run_phase(input phase_t p, input int from_k, input int to_k);
        for (int k = from_k; k >= to_k; k--) begin
            expect_out($sformatf("%s t=%0d", p.name, k), p.lights, p.walk, p.pend, digits(k));
            tick();
            check_out();
        end
    endtask

    // Checks that the countdown shows from_k..to_k; the check for each value precedes its tick
    task automatic walk_phase(input phase_t p, input int from_k, input int to_k);
        for (int k = from_k; k >= to_k; k--) begin
            expect_out($sformatf("%s t=%0d", p.name, k), p.lights, p.walk, p.pend, digits(k));
            check_out();
            tick();
        end
    endtask

    task automatic ped_pulse();
        ped_req = 1'b1;
        step(1);
        ped_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        seq1[0] = ph("AR2", L_AR, 1'b0, 1'b0, 2);
        seq1[1] = ph("MG",  L_MG, 1'b0, 1'b0, 15);
        seq1[2] = ph("MY",  L_MY, 1'b0, 1'b0, 3);
        seq1[3] = ph("AR1", L_AR, 1'b0, 1'b0, 2);
        seq1[4] = ph("SG",  L_SG, 1'b1, 1'b0, 10);
        seq1[5] = ph("SY",  L_SY, 1'b0, 1'b0, 3);
        seq1[6] = ph("AR2", L_AR, 1'b0, 1'b0, 2);

        rst_n = 1'b0; en = 1'b0; night_mode = 1'b0; ped_req = 1'b0;
        repeat (3) @(negedge clk);
        expect_out("reset", L_AR, 1'b0, 1'b0, digits(2));
        check_out();
        rst_n = 1'b1;
        en    = 1'b1;

        // Full cycle from reset
        for (int i = 0; i < 7; i++) walk_phase(seq1[i], seq1[i].n, 1);

        // Pedestrian request with shortening
        walk_phase(ph("MG", L_MG, 1'b0, 1'b0, 15), 15, 13);
        expect_out("MG t=12 before ped", L_MG, 1'b0, 1'b0, digits(12));
        check_out();
        ped_pulse();
        expect_out("ped latched", L_MG, 1'b0, 1'b1, digits(12));
        check_out();
        step(3);
        walk_phase(ph("MG short", L_MG, 1'b0, 1'b1, 5), 5, 1);
        walk_phase(ph("MY ped", L_MY, 1'b0, 1'b1, 3), 3, 1);
        walk_phase(ph("AR1 ped", L_AR, 1'b0, 1'b1, 2), 2, 1);
        for (int i = 4; i < 7; i++) walk_phase(seq1[i], seq1[i].n, 1);

        // Pedestrian request too late to shorten
        walk_phase(seq1[1], 15, 4);
        ped_pulse();
        expect_out("late ped latched", L_MG, 1'b0, 1'b1, digits(3));
        check_out();
        step(3);
        walk_phase(ph("MG late", L_MG, 1'b0, 1'b1, 2), 2, 1);
        walk_phase(ph("MY ped", L_MY, 1'b0, 1'b1, 3), 3, 1);
        walk_phase(ph("AR1 ped", L_AR, 1'b0, 1'b1, 2), 2, 1);
        walk_phase(seq1[4], 10, 8);

        // Enable freeze mid side green, prescaler part-way through a second
        step(2);
        en = 1'b0;
        step(25);
        expect_out("freeze mid", L_SG, 1'b1, 1'b0, digits(7));
        check_out();
        step(25);
        expect_out("freeze end", L_SG, 1'b1, 1'b0, digits(7));
        check_out();
        en = 1'b1;
        step(1);
        expect_out("resume no early tick", L_SG, 1'b1, 1'b0, digits(7));
        check_out();
        step(1);
        walk_phase(seq1[4], 6, 1);
        walk_phase(seq1[5], 3, 1);

        // Night mode entered at the all-red exit
        walk_phase(seq1[6], 2, 2);
        night_mode = 1'b1;
        walk_phase(seq1[6], 1, 1);
        expect_out("night b1", 6'b010_010, 1'b0, 1'b0, 14'h3FFF);
        check_out();
        tick();
        expect_out("night b0", 6'b000_000, 1'b0, 1'b0, 14'h3FFF);
        check_out();
        tick();
        expect_out("night b1 again", 6'b010_010, 1'b0, 1'b0, 14'h3FFF);
        check_out();
        night_mode = 1'b0;
        tick();
        walk_phase(seq1[6], 2, 1);
        walk_phase(seq1[1], 15, 1);

        // Asynchronous reset mid main yellow
        expect_out("MY before reset", L_MY, 1'b0, 1'b0, digits(3));
        check_out();
        step(1);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("async reset", L_AR, 1'b0, 1'b0, digits(2));
        check_out();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) walk_phase(seq1[i], seq1[i].n, 1);
        expect_out("MG after rerun", L_MG, 1'b0, 1'b0, digits(15));
        check_out();

        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard drain: %0d expectations left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
